// File: rtl/nbit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nbit_serial_subtractor
// Description : Digit-serial N-bit unsigned subtractor. Computes
//               d = a - b - bin, K bits per clock, through a registered
//               borrow chain. The operation takes N/K RUN cycles. Valid/ready
//               handshakes are used on the input side and on the output side.
//               Optional feature: define SUB_SIGNED_OVF_EN to add the ovf
//               output, which is the two's-complement overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_serial_subtractor #(
    parameter int N = 8,   // operand/result width, must be a multiple of K
    parameter int K = 2    // digit width, 1..N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    // Number of digits per operation and the counter that walks them.
    localparam int             DIGITS     = N / K;
    localparam int             CW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]  LAST_DIGIT = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [N-1:0]   a_sh;       // minuend, shifted right one digit per RUN cycle
    logic [N-1:0]   b_sh;       // subtrahend, shifted in step with a_sh
    logic           br;         // borrow carried between digits
    logic [CW-1:0]  cnt;        // index of the digit being processed
    logic [K-1:0]   digit;      // difference bits of the current digit
    logic [K:0]     chain;      // ripple borrow through the current digit
    logic [N-1:0]   d_next;     // d with the current digit shifted in at the MSB
    logic           last_digit;

`ifdef SUB_SIGNED_OVF_EN
    logic           a_msb;      // sign bits of the original operands, kept for ovf
    logic           b_msb;
`endif

    assign last_digit = (cnt == LAST_DIGIT);

    // ------------------------------------------------------------------------
    // K-bit ripple-borrow slice, fed by the low digit of the shifted operands
    // ------------------------------------------------------------------------
    assign chain[0] = br;

    generate
        for (genvar i = 0; i < K; i++) begin : g_bit
            assign digit[i]   = a_sh[i] ^ b_sh[i] ^ chain[i];
            assign chain[i+1] = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & chain[i]);
        end
    endgenerate

    // The result fills from the MSB side. After DIGITS shifts, the first
    // digit has reached bit 0. With K == N there is nothing to keep.
    generate
        if (K == N) begin : g_full_digit
            assign d_next = digit;
        end else begin : g_part_digit
            assign d_next = {digit, d[N-1:K]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------

    // State register. Reset lands in IDLE and drops any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. in_valid is only looked at in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Both handshake outputs decode the state register directly. This keeps
    // out_ready from reaching in_ready in the same cycle.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Capture operands on accept, step one digit per RUN cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
`ifdef SUB_SIGNED_OVF_EN
                        a_msb <= a[N-1];
                        b_msb <= b[N-1];
`endif
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> K;
                    b_sh <= b_sh >> K;
                    br   <= chain[K];
                    d    <= d_next;
                    cnt  <= cnt + CW'(1);
                    if (last_digit) begin
                        bout <= chain[K];
`ifdef SUB_SIGNED_OVF_EN
                        // The top bit of the last digit becomes d[N-1].
                        ovf  <= (a_msb ^ b_msb) & (digit[K-1] ^ a_msb);
`endif
                    end
                end
                default: begin
                    // DONE: results stay put until the consumer takes them.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbit_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_serial_subtractor
// Description : Self-checking bench for nbit_serial_subtractor. The main
//               instance uses N=8, K=2. Three more instances with K=1, K=4
//               and K=8 cover the sweep with in_valid held high. The ovf
//               checks are compiled only when SUB_SIGNED_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks   = 0;
    int         failures = 0;

    // main instance (K=2)
    logic       iv;
    logic [7:0] ia;
    logic [7:0] ib;
    logic       ibin;
    logic       ordy;
    logic       rdy;
    logic       ov;
    logic [7:0] dd;
    logic       bo;

    // sweep instances share stimulus
    logic       sv;
    logic [7:0] sa;
    logic [7:0] sb;
    logic       sbin;
    logic       sordy;
    logic       rdy1, rdy4, rdy8;
    logic       ov1, ov4, ov8;
    logic [7:0] d1, d4, d8;
    logic       bo1, bo4, bo8;

`ifdef SUB_SIGNED_OVF_EN
    logic       ovf;
    logic       ovf1, ovf4, ovf8;
`endif

    always #5 clk = ~clk;

    nbit_serial_subtractor #(.N(8), .K(2)) u_k2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy),
        .a(ia), .b(ib), .bin(ibin), .out_valid(ov), .out_ready(ordy),
        .d(dd), .bout(bo)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf)
`endif
    );

    nbit_serial_subtractor #(.N(8), .K(1)) u_k1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy1),
        .a(sa), .b(sb), .bin(sbin), .out_valid(ov1), .out_ready(sordy),
        .d(d1), .bout(bo1)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf1)
`endif
    );

    nbit_serial_subtractor #(.N(8), .K(4)) u_k4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy4),
        .a(sa), .b(sb), .bin(sbin), .out_valid(ov4), .out_ready(sordy),
        .d(d4), .bout(bo4)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf4)
`endif
    );

    nbit_serial_subtractor #(.N(8), .K(8)) u_k8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(rdy8),
        .a(sa), .b(sb), .bin(sbin), .out_valid(ov8), .out_ready(sordy),
        .d(d8), .bout(bo8)
`ifdef SUB_SIGNED_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // Drive one operation into the K=2 instance and wait (bounded) for out_valid.
    // lat counts the clock edges after the accept edge. The accept edge is
    // clock 1 of N/K+1, so out_valid is expected after lat == N/K == 4.
    task automatic issue_op(input logic [7:0] av, input logic [7:0] bv, input logic bv_in,
                            output int lat, output bit timeout);
        @(negedge clk);
        iv   = 1'b1;
        ia   = av;
        ib   = bv;
        ibin = bv_in;
        @(posedge clk);
        @(negedge clk);
        iv   = 1'b0;
        ia   = ~av;
        ib   = ~bv;
        ibin = ~bv_in;
        lat     = 0;
        timeout = 1'b0;
        while (!ov && !timeout) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat > 20) timeout = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv = 1'b0; ia = '0; ib = '0; ibin = 1'b0; ordy = 1'b1;
        sv = 1'b0; sa = '0; sb = '0; sbin = 1'b0; sordy = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", rdy); end
        checks++; if (ov !== 1'b0)  begin failures++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
        checks++; if (dd !== 8'h00) begin failures++; $display("FAIL reset_d: got %h expected 00", dd); end
        checks++; if (bo !== 1'b0)  begin failures++; $display("FAIL reset_bout: got %b expected 0", bo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] va [3] = '{8'h5A, 8'h00, 8'h80};
        logic [7:0] vb [3] = '{8'h23, 8'h01, 8'h01};
        logic [7:0] ed [3] = '{8'h37, 8'hFF, 8'h7F};
        logic       eb [3] = '{1'b0,  1'b1,  1'b0};
        logic       eo [3] = '{1'b0,  1'b0,  1'b1};
        int lat;
        bit to;
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue_op(va[i], vb[i], 1'b0, lat, to);
            checks++; if (to || lat != 4) begin failures++; $display("FAIL basic_latency[%0d]: got %0d expected 4", i, lat); end
            checks++; if (dd !== ed[i]) begin failures++; $display("FAIL basic_d[%0d]: got %h expected %h", i, dd, ed[i]); end
            checks++; if (bo !== eb[i]) begin failures++; $display("FAIL basic_bout[%0d]: got %b expected %b", i, bo, eb[i]); end
`ifdef SUB_SIGNED_OVF_EN
            checks++; if (ovf !== eo[i]) begin failures++; $display("FAIL basic_ovf[%0d]: got %b expected %b", i, ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("unexpected table entry");
`endif
            @(posedge clk);
            @(negedge clk);
            checks++; if (rdy !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL basic_release[%0d]: got rdy=%b ov=%b expected rdy=1 ov=0", i, rdy, ov); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        ordy = 1'b0;
        issue_op(8'h10, 8'h0F, 1'b1, lat, to);
        checks++; if (to || lat != 4) begin failures++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        checks++; if (dd !== 8'h00 || bo !== 1'b0) begin failures++; $display("FAIL bp_result: got d=%h bout=%b expected d=00 bout=0", dd, bo); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov !== 1'b1 || rdy !== 1'b0 || dd !== 8'h00 || bo !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b d=%h bout=%b expected ov=1 rdy=0 d=00 bout=0", c, ov, rdy, dd, bo);
            end
        end
        ordy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rdy !== 1'b1 || ov !== 1'b0) begin failures++; $display("FAIL bp_release: got rdy=%b ov=%b expected rdy=1 ov=0", rdy, ov); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        bit saw_ov;
        ordy = 1'b1;
        @(negedge clk);
        iv = 1'b1; ia = 8'hFF; ib = 8'h01; ibin = 1'b0;
        @(posedge clk);          // accept edge
        @(negedge clk);
        iv = 1'b0;
        @(posedge clk);          // second RUN cycle starts here
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1 || ov !== 1'b0 || dd !== 8'h00 || bo !== 1'b0) begin
            failures++;
            $display("FAIL midrun_async_reset: got rdy=%b ov=%b d=%h bout=%b expected rdy=1 ov=0 d=00 bout=0", rdy, ov, dd, bo);
        end
        saw_ov = 1'b0;
        repeat (2) begin @(negedge clk); if (ov) saw_ov = 1'b1; end
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); if (ov) saw_ov = 1'b1; end
        checks++; if (saw_ov) begin failures++; $display("FAIL midrun_no_out_valid: got out_valid=1 expected 0"); end
        issue_op(8'h03, 8'h02, 1'b0, lat, to);
        checks++; if (to || dd !== 8'h01 || bo !== 1'b0) begin failures++; $display("FAIL post_reset_op: got d=%h bout=%b expected d=01 bout=0", dd, bo); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [8:0] q1 [$];
        logic [8:0] q4 [$];
        logic [8:0] q8 [$];
        logic [8:0] e;
        logic [8:0] exp_v;
        int n1 = 0, n4 = 0, n8 = 0;
        @(negedge clk);
        sv = 1'b1; sa = 8'($urandom_range(0, 255)); sb = 8'($urandom_range(0, 255)); sbin = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 340; cyc++) begin
            if (cyc == 300) sv = 1'b0;
            // results being consumed at the coming edge
            if (ov1) begin
                checks++; n1++;
                exp_v = (q1.size() > 0) ? q1.pop_front() : 9'h1xx;
                if ({bo1, d1} !== exp_v) begin failures++; $display("FAIL sweep_k1: got %h expected %h", {bo1, d1}, exp_v); end
            end
            if (ov4) begin
                checks++; n4++;
                exp_v = (q4.size() > 0) ? q4.pop_front() : 9'h1xx;
                if ({bo4, d4} !== exp_v) begin failures++; $display("FAIL sweep_k4: got %h expected %h", {bo4, d4}, exp_v); end
            end
            if (ov8) begin
                checks++; n8++;
                exp_v = (q8.size() > 0) ? q8.pop_front() : 9'h1xx;
                if ({bo8, d8} !== exp_v) begin failures++; $display("FAIL sweep_k8: got %h expected %h", {bo8, d8}, exp_v); end
            end
            // operands being accepted at the coming edge
            e = {1'b0, sa} - {1'b0, sb} - {8'b0, sbin};
            if (sv && rdy1) q1.push_back(e);
            if (sv && rdy4) q4.push_back(e);
            if (sv && rdy8) q8.push_back(e);
            @(negedge clk);
            sa = 8'($urandom_range(0, 255)); sb = 8'($urandom_range(0, 255)); sbin = 1'($urandom_range(0, 1));
        end
        checks++; if (q1.size() != 0 || q4.size() != 0 || q8.size() != 0) begin failures++; $display("FAIL sweep_drain: got pending %0d/%0d/%0d expected 0/0/0", q1.size(), q4.size(), q8.size()); end
        checks++; if (n1 < 20 || n4 < 40 || n8 < 80) begin failures++; $display("FAIL sweep_throughput: got %0d/%0d/%0d results expected at least 20/40/80", n1, n4, n8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
